// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin arbiter sharing the register-file write port between the
// ALU (A) and load (B) write-back paths, with a registered write port and a contention counter.
module wb_port_arbiter (
    input  logic        clk,
    input  logic        rstd,
    input  logic        hold,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        we,
    output logic [4:0]  w_addr,
    output logic [31:0] w_data,
    output logic [15:0] conflict_cnt
);
    logic        last_b_q, last_b_d;
    logic        we_q, we_d;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [15:0] cnt_q, cnt_d;
    logic        xfer;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;

    // last_b_q names the previous winner; under contention the other side gets the grant
    assign a_ready  = rstd && !hold && a_valid && (!b_valid || last_b_q);
    assign b_ready  = rstd && !hold && b_valid && (!a_valid || !last_b_q);
    assign xfer     = a_ready || b_ready;
    assign sel_addr = a_ready ? a_addr : b_addr;
    assign sel_data = a_ready ? a_data : b_data;

    always_comb begin
        last_b_d = xfer ? b_ready : last_b_q;
        we_d     = xfer && (sel_addr != 5'd0);
        addr_d   = xfer ? sel_addr : addr_q;
        data_d   = xfer ? sel_data : data_q;
        cnt_d    = (a_valid && b_valid && !hold && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            last_b_q <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= 5'd0;
            data_q   <= 32'd0;
            cnt_q    <= 16'd0;
        end else begin
            last_b_q <= last_b_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
        end
    end

    assign we           = we_q;
    assign w_addr       = addr_q;
    assign w_data       = data_q;
    assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed vectors with hand-computed expectations for wb_port_arbiter.
module tb_wb_port_arbiter;
    logic        clk = 1'b0;
    logic        rstd = 1'b0;
    logic        hold = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, we;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [15:0] conflict_cnt;
    int          n_vec = 0, n_err = 0;

    wb_port_arbiter dut (
        .clk(clk), .rstd(rstd), .hold(hold),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .we(we), .w_addr(w_addr), .w_data(w_data), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] a_tab [4] = '{5'd1, 5'd2, 5'd2, 5'd2};
    logic [4:0] b_tab [4] = '{5'd3, 5'd3, 5'd4, 5'd4};
    logic [4:0] w_tab [4] = '{5'd1, 5'd3, 5'd2, 5'd4};

    initial begin
        // reset held with A pending
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h1;
        tick(); tick();
        chk("rst_we", we, 0);
        chk("rst_waddr", w_addr, 0);
        chk("rst_wdata", w_data, 0);
        chk("rst_cnt", conflict_cnt, 0);
        chk("rst_aready", a_ready, 0);

        // single requester
        rstd = 1'b1;
        a_addr = 5'd5; a_data = 32'hDEADBEEF;
        #1 chk("single_aready", a_ready, 1);
        chk("single_bready", b_ready, 0);
        tick();
        a_valid = 1'b0;
        chk("single_we", we, 1);
        chk("single_waddr", w_addr, 5);
        chk("single_wdata", w_data, 32'hDEADBEEF);
        tick();
        chk("single_we_off", we, 0);
        chk("single_waddr_hold", w_addr, 5);

        // contention right after an A grant goes to B, then async reset mid-stream
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h9;
        b_valid = 1'b1; b_addr = 5'd10; b_data = 32'hA;
        #1 chk("rr_bready", b_ready, 1);
        chk("rr_aready", a_ready, 0);
        tick();
        chk("rr_waddr", w_addr, 10);
        chk("rr_cnt", conflict_cnt, 1);
        #1 rstd = 1'b0;
        #1 chk("async_we", we, 0);
        chk("async_waddr", w_addr, 0);
        chk("async_wdata", w_data, 0);
        chk("async_cnt", conflict_cnt, 0);
        chk("async_ready", {a_ready, b_ready}, 0);
        #1 rstd = 1'b1;

        // contention: A first after reset, then alternate
        for (int i = 0; i < 4; i++) begin
            a_addr = a_tab[i]; a_data = 32'h100 + a_tab[i];
            b_addr = b_tab[i]; b_data = 32'h100 + b_tab[i];
            #1 chk($sformatf("cont_ready%0d", i), {a_ready, b_ready}, (i % 2 == 0) ? 2 : 1);
            tick();
            chk($sformatf("cont_we%0d", i), we, 1);
            chk($sformatf("cont_waddr%0d", i), w_addr, w_tab[i]);
            chk($sformatf("cont_wdata%0d", i), w_data, 32'h100 + w_tab[i]);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        chk("cont_cnt", conflict_cnt, 4);
        chk("cont_we_off", we, 0);

        // register zero: handshake completes, no write enable
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h55;
        #1 chk("r0_bready", b_ready, 1);
        tick();
        b_valid = 1'b0;
        chk("r0_we", we, 0);
        chk("r0_waddr", w_addr, 0);
        chk("r0_wdata", w_data, 32'h55);

        // hold blocks grants and counting; B won last, so A wins on release
        a_valid = 1'b1; a_addr = 5'd12; a_data = 32'hC;
        b_valid = 1'b1; b_addr = 5'd13; b_data = 32'hD;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("hold_ready%0d", i), {a_ready, b_ready}, 0);
            tick();
            chk($sformatf("hold_we%0d", i), we, 0);
            chk($sformatf("hold_cnt%0d", i), conflict_cnt, 4);
        end
        hold = 1'b0;
        #1 chk("hold_rel_ready", {a_ready, b_ready}, 2);
        tick();
        chk("hold_rel_waddr", w_addr, 12);
        chk("hold_rel_cnt", conflict_cnt, 5);

        // saturation
        repeat (65529) tick();
        chk("sat_fffe", conflict_cnt, 16'hFFFE);
        tick();
        chk("sat_ffff", conflict_cnt, 16'hFFFF);
        repeat (4470) tick();
        chk("sat_hold", conflict_cnt, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
